sync_fifo_fwft: RTL and testbench

Single-clock first-word-fall-through FIFO built around a `simple_dual_port_ram` instance, with both RAM ports tied to one clock. It supplies the RAM's write address and write enable, and its registered read address. It then consumes the RAM's one-cycle-latency `read_data` and presents the head word directly on `dout`. It sits between any streaming producer/consumer pair in the design that needs block-RAM-backed buffering with show-ahead output.

---
 rtl/sync_fifo_fwft_pkg.sv | 8 +
 rtl/sync_fifo_fwft_ram.sv | 28 ++
 rtl/sync_fifo_fwft.sv | 82 ++++++++
 tb/tb_sync_fifo_fwft.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared defaults for the show-ahead FIFO.
// Holds the default word width and depth used by sync_fifo_fwft.
package sync_fifo_fwft_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_ENTRIES = 16;

endpackage

// File: rtl/sync_fifo_fwft_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports: wclk/we/waddr/wdata write side; rclk/raddr/read_data read side.
module simple_dual_port_ram #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 16
) (
    input  logic                       wclk,
    input  logic                       we,
    input  logic [$clog2(ENTRIES)-1:0] waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rclk,
    input  logic [$clog2(ENTRIES)-1:0] raddr,
    output logic [WIDTH-1:0]           read_data
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge wclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge rclk) begin
        read_data <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO over a registered-read dual-port RAM.
// Ports: clk, rst_n, din/wr_en/full, dout/rd_en/empty, count.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ENTRIES = DEF_ENTRIES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wr_en,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(ENTRIES):0] count
);

    localparam int ADDR_W = $clog2(ENTRIES);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] raddr;
    logic              push;
    logic              pop;
    logic              collide;
    logic [CNT_W-1:0]  count_nxt;

    assign push = wr_en & ~full;
    assign pop  = rd_en & ~empty;

    // Look one slot ahead on a pop so the next head is ready after the edge.
    assign raddr = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Writing the slot being read returns stale data; hide it behind empty.
    assign collide = push & (wr_ptr == raddr);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0) | collide;
            full  <= (count_nxt == CNT_W'(ENTRIES));
        end
    end

    simple_dual_port_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES)
    ) u_ram (
        .wclk      (clk),
        .we        (push),
        .waddr     (wr_ptr),
        .wdata     (din),
        .rclk      (clk),
        .raddr     (raddr),
        .read_data (dout)
    );

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: directed vectors plus a scoreboard monitor.
// Flags and pop data are checked against a small occupancy model.
module tb_sync_fifo_fwft;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       wr_en;
    logic       full;
    logic       rd_en;
    logic [7:0] dout;
    logic       empty;
    logic [2:0] count;

    int vecs = 0;
    int errs = 0;

    logic [7:0] q[$];
    int         m_occ;
    logic       m_empty;
    logic       m_full;

    always #5 clk = ~clk;

    sync_fifo_fwft #(
        .WIDTH   (8),
        .ENTRIES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .wr_en (wr_en),
        .full  (full),
        .rd_en (rd_en),
        .dout  (dout),
        .empty (empty),
        .count (count)
    );

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Apply inputs for one cycle, return 1 time unit after the edge.
    task automatic drive(input logic w, input logic [7:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares flags every cycle, pops the scoreboard on reads.
    initial begin
        bit push_ok;
        bit pop_ok;
        bit coll;
        int occ_n;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_occ   = 0;
                m_empty = 1'b1;
                m_full  = 1'b0;
            end else begin
                chk("mon_count", int'(count), m_occ);
                chk("mon_empty", int'(empty), int'(m_empty));
                chk("mon_full", int'(full), int'(m_full));
                push_ok = wr_en && !m_full;
                pop_ok  = rd_en && !m_empty;
                if (pop_ok) begin
                    if (q.size() == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL sb_underflow: pop with no word");
                    end else begin
                        chk("pop_data", int'(dout), int'(q.pop_front()));
                    end
                end
                if (push_ok) begin
                    q.push_back(din);
                end
                coll  = push_ok && (m_occ == (pop_ok ? 1 : 0));
                occ_n = m_occ + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
                m_occ   = occ_n;
                m_empty = (occ_n == 0) || coll;
                m_full  = (occ_n == 4);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);

        // Push into empty: masked one cycle, then visible.
        drive(1, 8'hA1, 0);
        chk("s1_empty_c1", int'(empty), 1);
        chk("s1_count_c1", int'(count), 1);
        drive(0, 8'h00, 0);
        chk("s1_empty_c2", int'(empty), 0);
        chk("s1_dout_c2", int'(dout), 8'hA1);
        drive(0, 8'h00, 1);
        chk("s1_drained", int'(empty), 1);

        // Fill to full, overflow push dropped, drain at full rate.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 8'(i), 0);
        end
        chk("s2_full", int'(full), 1);
        chk("s2_count4", int'(count), 4);
        drive(1, 8'h05, 0);
        chk("s2_count_ovf", int'(count), 4);
        chk("s2_head", int'(dout), 8'h01);
        for (int i = 1; i <= 4; i++) begin
            chk("s2_pop_dout", int'(dout), i);
            chk("s2_pop_empty", int'(empty), 0);
            drive(0, 8'h00, 1);
        end
        chk("s2_empty_end", int'(empty), 1);
        chk("s2_count_end", int'(count), 0);

        // Pop while empty is ignored.
        drive(0, 8'h00, 1);
        chk("s3_count", int'(count), 0);
        chk("s3_empty", int'(empty), 1);
        drive(1, 8'h33, 0);
        chk("s3_empty_c1", int'(empty), 1);
        drive(0, 8'h00, 0);
        chk("s3_dout", int'(dout), 8'h33);
        chk("s3_empty_c2", int'(empty), 0);
        drive(0, 8'h00, 1);

        // Occupancy 1: push and pop together collide.
        drive(1, 8'h10, 0);
        drive(0, 8'h00, 0);
        chk("s4_head", int'(dout), 8'h10);
        drive(1, 8'h20, 1);
        chk("s4_masked", int'(empty), 1);
        chk("s4_count_m", int'(count), 1);
        drive(0, 8'h00, 0);
        chk("s4_unmasked", int'(empty), 0);
        chk("s4_dout", int'(dout), 8'h20);
        chk("s4_count", int'(count), 1);
        drive(0, 8'h00, 1);

        // Full: push with pop accepts only the pop.
        drive(1, 8'hC1, 0);
        drive(1, 8'hC2, 0);
        drive(1, 8'hC3, 0);
        drive(1, 8'hC4, 0);
        chk("s5_full", int'(full), 1);
        drive(1, 8'h99, 1);
        chk("s5_count", int'(count), 3);
        chk("s5_full_off", int'(full), 0);
        chk("s5_head", int'(dout), 8'hC2);
        repeat (3) drive(0, 8'h00, 1);
        chk("s5_empty", int'(empty), 1);

        // Random traffic with a mid-stream reset.
        begin
            int pushes = 0;
            for (int i = 0; i < 1000 && pushes < 200; i++) begin
                if (i == 120) begin
                    rst_n = 1'b0;
                    wr_en = 1'b0;
                    rd_en = 1'b0;
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    chk("r_rst_empty", int'(empty), 1);
                    chk("r_rst_count", int'(count), 0);
                end
                if ($urandom_range(0, 3) != 0) begin
                    pushes++;
                    drive(1, 8'($urandom), 1'($urandom));
                end else begin
                    drive(0, 8'($urandom), 1'($urandom));
                end
            end
        end
        repeat (8) drive(0, 8'h00, 1);
        chk("r_empty_end", int'(empty), 1);
        chk("r_count_end", int'(count), 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
